// File: rtl/rep_add_mult_pkg.sv
// Shared types for the repeated-addition multiplier.
package rep_add_mult_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rep_add_mult_if.sv
// Start/abort request and result bus of the multiplier.
interface rep_add_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               ready;
  logic               done;
  logic               busy;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, abort, a_in, b_in,
    input  ready, done, busy, product
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output ready, done, busy, product
  );
endinterface

// File: rtl/rep_add_mult_ctrl.sv
// Control FSM of the multiplier: turns start/abort/b_zero into datapath strobes.
module rep_add_mult_ctrl
  import rep_add_mult_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic b_zero,
  output logic ld,
  output logic add_dec,
  output logic clr,
  output logic ready,
  output logic busy,
  output logic done
);
  state_t state, state_nxt;

  // State register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and strobes; abort outranks the loop-end test.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    add_dec   = 1'b0;
    clr       = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          ld        = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (b_zero) begin
          state_nxt = DONE;
        end else begin
          add_dec = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/rep_add_mult.sv
// Repeated-addition multiplier: P = A * B by adding A to P, B times.
// Optional build macro OPERAND_SWAP_EN loops on the smaller operand.
module rep_add_mult
  import rep_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  rep_add_mult_if.slave bus
);
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   a_ld, b_ld;
  logic [2*WIDTH-1:0] p_q;
  logic               ld, add_dec, clr, b_zero;

`ifdef OPERAND_SWAP_EN
  // Put the larger operand in A so the loop runs min(a,b) times.
  logic swap;
  assign swap = (bus.b_in > bus.a_in);
  assign a_ld = swap ? bus.b_in : bus.a_in;
  assign b_ld = swap ? bus.a_in : bus.b_in;
`else
  assign a_ld = bus.a_in;
  assign b_ld = bus.b_in;
`endif

  assign b_zero = (b_q == '0);

  rep_add_mult_ctrl u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .abort   (bus.abort),
    .b_zero  (b_zero),
    .ld      (ld),
    .add_dec (add_dec),
    .clr     (clr),
    .ready   (bus.ready),
    .busy    (bus.busy),
    .done    (bus.done)
  );

  // Operand and accumulator registers; B only decrements while nonzero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else if (ld) begin
      a_q <= a_ld;
      b_q <= b_ld;
      p_q <= '0;
    end else if (clr) begin
      p_q <= '0;
    end else if (add_dec) begin
      p_q <= p_q + {{WIDTH{1'b0}}, a_q};
      b_q <= b_q - 1'b1;
    end
  end

  assign bus.product = p_q;
endmodule

// File: tb/tb_rep_add_mult.sv
// Directed bench for rep_add_mult (WIDTH=8): vector table plus abort/reset sequences.
module tb_rep_add_mult;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rep_add_mult_if #(.WIDTH(W)) bus();

  rep_add_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             done_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one operation, find the done cycle, check result and handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] prod, input int done_exp);
    int cyc;
    int done_cyc;
    logic [2*W-1:0] p_at_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_c1", bus.busy, 1);
    done_cyc = -1;
    p_at_done = '0;
    while (cyc < 400) begin
      if (bus.done) begin
        done_cyc  = cyc;
        p_at_done = bus.product;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_cycle", done_cyc, done_exp);
    chk("product", p_at_done, prod);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("ready_after", bus.ready, 1);
    chk("product_hold", bus.product, prod);
  endtask

  initial begin
    int cyc;
    bit seen;
    bus.start = 1'b0; bus.abort = 1'b0; bus.a_in = '0; bus.b_in = '0;

    vecs[0] = '{8'd3,   8'd4,   16'd12,    6};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01,  257};
    vecs[2] = '{8'd7,   8'd0,   16'd0,     2};
`ifdef OPERAND_SWAP_EN
    vecs[3] = '{8'd0,   8'd5,   16'd0,     2};
    vecs[4] = '{8'd2,   8'd200, 16'd400,   4};
    vecs[5] = '{8'd5,   8'd9,   16'd45,    7};
`else
    vecs[3] = '{8'd0,   8'd5,   16'd0,     7};
    vecs[4] = '{8'd2,   8'd200, 16'd400,   202};
    vecs[5] = '{8'd5,   8'd9,   16'd45,    11};
`endif
    vecs[6] = '{8'd13,  8'd11,  16'd143,   13};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_product", bus.product, 0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].done_cyc);

    // Abort sequence: ignored restart during RUN, abort in cycle 4
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 8'd9; bus.b_in = 8'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      if (cyc == 2) begin bus.start = 1'b1; bus.a_in = 8'd1; bus.b_in = 8'd1; end
      if (cyc == 3) bus.start = 1'b0;
      if (cyc == 4) bus.abort = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.abort = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_product", bus.product, 0);
    seen = 1'b0;
    repeat (15) begin
      if (bus.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", seen, 0);
`ifdef OPERAND_SWAP_EN
    run_op(8'd9, 8'd10, 16'd90, 11);
`else
    run_op(8'd9, 8'd10, 16'd90, 12);
`endif

    // Abort held in the start cycle is ignored in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.a_in = 8'd4; bus.b_in = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("idle_abort_busy", bus.busy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_abort_product", bus.product, 4);

    // Reset in mid-RUN cycle 3
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 8'd3; bus.b_in = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst_ready", bus.ready, 1);
    chk("midrun_rst_busy", bus.busy, 0);
    chk("midrun_rst_done", bus.done, 0);
    chk("midrun_rst_product", bus.product, 0);

    // Reset together with start in IDLE: start not accepted
    bus.start = 1'b1; bus.a_in = 8'd5; bus.b_in = 8'd5;
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b0;
    chk("rst_start_ready", bus.ready, 1);
    chk("rst_start_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("rst_start_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
